// File: rtl/stdp_weight_update.sv
// Per-synapse stochastic STDP weight updater.
// Samples the one-hot STDP case at each gamma pulse and applies a
// saturating +1/-1 to the weight with a per-case probability.
//
// Ports:
//   clk        unit clock
//   rst        asynchronous active-high reset
//   grst       one-cycle gamma pulse
//   stdp_cases [0]=capture [1]=minus [2]=search [3]=backoff
//   w_load     weight load strobe (IDLE only)
//   w_in       weight value for w_load
//   weight     current synaptic weight
//   upd_busy   update FSM not IDLE
//   upd_done   one-cycle pulse in the weight-write cycle
//   case_err   sticky: more than one case bit sampled at once
module stdp_weight_update #(
    parameter int unsigned       WBITS     = 3,
    parameter logic [WBITS-1:0]  INIT_W    = '0,
    parameter logic [15:0]       P_CAPTURE = 16'h8000,
    parameter logic [15:0]       P_MINUS   = 16'h8000,
    parameter logic [15:0]       P_SEARCH  = 16'h0400,
    parameter logic [15:0]       P_BACKOFF = 16'h8000,
    parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grst,
    input  logic [3:0]       stdp_cases,
    input  logic             w_load,
    input  logic [WBITS-1:0] w_in,
    output logic [WBITS-1:0] weight,
    output logic             upd_busy,
    output logic             upd_done,
    output logic             case_err
);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        APPLY
    } state_t;

    localparam logic [WBITS-1:0] W_MAX = {WBITS{1'b1}};
    localparam logic [WBITS-1:0] W_MIN = '0;
    // Galois feedback mask for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       case_q;
    logic [3:0]       sel_q;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_nxt;
    logic             hit_q;
    logic             inc_q;
    logic [WBITS-1:0] weight_q;
    logic [WBITS-1:0] weight_upd;

    logic             latch_sel;
    logic             in_idle;
    logic             in_draw;
    logic             in_apply;
    logic [15:0]      p_sel;
    logic             dir_inc;
    logic             multi_hot;
    logic             hit;

    assign weight   = weight_q;
    assign in_idle  = (state == IDLE);
    assign in_draw  = (state == DRAW);
    assign in_apply = (state == APPLY);
    assign upd_busy = !in_idle;
    assign upd_done = in_apply;

    // Galois right shift; the seed is nonzero so the state never
    // reaches zero, which makes a zero threshold a true "never".
    always_comb begin
        lfsr_nxt = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_nxt = lfsr_nxt ^ LFSR_TAPS;
        end
    end

    // Priority select: capture > minus > search > backoff
    always_comb begin
        p_sel   = P_BACKOFF;
        dir_inc = 1'b0;
        if (sel_q[0]) begin
            p_sel   = P_CAPTURE;
            dir_inc = 1'b1;
        end else if (sel_q[1]) begin
            p_sel   = P_MINUS;
            dir_inc = 1'b0;
        end else if (sel_q[2]) begin
            p_sel   = P_SEARCH;
            dir_inc = 1'b1;
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves
    // something behind.
    assign multi_hot = ((sel_q & (sel_q - 4'd1)) != 4'd0);
    assign hit       = (lfsr <= p_sel);

    // Saturating step in the registered direction
    always_comb begin
        weight_upd = weight_q;
        if (inc_q) begin
            if (weight_q != W_MAX) begin
                weight_upd = weight_q + 1'b1;
            end
        end else begin
            if (weight_q != W_MIN) begin
                weight_upd = weight_q - 1'b1;
            end
        end
    end

    // A load in the gamma cycle takes precedence and skips the update.
    always_comb begin
        state_nxt = state;
        latch_sel = 1'b0;
        unique case (state)
            IDLE: begin
                if (grst && !w_load && (case_q != 4'd0)) begin
                    latch_sel = 1'b1;
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                state_nxt = APPLY;
            end
            APPLY: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            case_q <= 4'd0;
            lfsr   <= LFSR_SEED;
        end else begin
            case_q <= stdp_cases;
            lfsr   <= lfsr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= 4'd0;
            hit_q    <= 1'b0;
            inc_q    <= 1'b0;
            case_err <= 1'b0;
        end else begin
            if (latch_sel) begin
                sel_q <= case_q;
            end
            if (in_draw) begin
                hit_q <= hit;
                inc_q <= dir_inc;
                if (multi_hot) begin
                    case_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_q <= INIT_W;
        end else if (in_idle && w_load) begin
            weight_q <= w_in;
        end else if (in_apply && hit_q) begin
            weight_q <= weight_upd;
        end
    end

endmodule

// File: tb/tb_stdp_weight_update.sv
// Testbench for stdp_weight_update: table-driven gamma vectors,
// LFSR reference model and a weight scoreboard keyed on upd_done.
module tb_stdp_weight_update;

    localparam int unsigned WBITS     = 3;
    localparam logic [2:0]  INIT_W    = 3'd3;
    localparam logic [15:0] P_CAPTURE = 16'hFFFF;
    localparam logic [15:0] P_MINUS   = 16'h8000;
    localparam logic [15:0] P_SEARCH  = 16'h0000;
    localparam logic [15:0] P_BACKOFF = 16'hFFFF;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       grst;
    logic [3:0] stdp_cases;
    logic       w_load;
    logic [2:0] w_in;
    logic [2:0] weight;
    logic       upd_busy;
    logic       upd_done;
    logic       case_err;

    always #5 clk = ~clk;

    stdp_weight_update #(
        .WBITS     (WBITS),
        .INIT_W    (INIT_W),
        .P_CAPTURE (P_CAPTURE),
        .P_MINUS   (P_MINUS),
        .P_SEARCH  (P_SEARCH),
        .P_BACKOFF (P_BACKOFF),
        .LFSR_SEED (SEED)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .grst       (grst),
        .stdp_cases (stdp_cases),
        .w_load     (w_load),
        .w_in       (w_in),
        .weight     (weight),
        .upd_busy   (upd_busy),
        .upd_done   (upd_done),
        .case_err   (case_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference LFSR: 16-bit Galois, x^16+x^14+x^13+x^11+1
    logic [15:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_m <= SEED;
        end else if (lfsr_m[0]) begin
            lfsr_m <= (lfsr_m >> 1) ^ 16'hB400;
        end else begin
            lfsr_m <= lfsr_m >> 1;
        end
    end

    // Scoreboard: expected weight pushed at the DRAW cycle, popped one
    // cycle after upd_done is seen.
    logic [2:0] exp_q[$];
    bit         pend = 1'b0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            chk("sb_weight", weight, exp_q.pop_front());
        end
        if (upd_done === 1'b1) begin
            done_cnt++;
            chk("sb_done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) pend = 1'b1;
        end
    end

    logic [2:0] w_m;
    bit         err_m;

    task automatic load_w(input logic [2:0] v);
        @(negedge clk);
        w_load = 1'b1;
        w_in   = v;
        @(negedge clk);
        w_load = 1'b0;
        w_m    = v;
        chk("load_weight", weight, v);
    endtask

    // One gamma: case held a cycle, then grst (optionally held one more
    // cycle to probe the busy-ignore path).
    task automatic gamma(input logic [3:0] cs, input bit ld,
                         input logic [2:0] wi, input bit hold,
                         input bit use_tbl, input logic [2:0] tw);
        bit          go;
        bit          inc;
        logic [15:0] p;
        logic [2:0]  nw;
        @(negedge clk);
        stdp_cases = cs;
        grst   = 1'b0;
        w_load = 1'b0;
        @(negedge clk);
        grst   = 1'b1;
        w_load = ld;
        w_in   = wi;
        @(negedge clk);
        if (!hold) grst = 1'b0;
        w_load = 1'b0;
        go = !ld && (cs != 4'd0);
        if (ld) w_m = wi;
        if (go) begin
            if (cs[0]) begin
                p = P_CAPTURE; inc = 1'b1;
            end else if (cs[1]) begin
                p = P_MINUS; inc = 1'b0;
            end else if (cs[2]) begin
                p = P_SEARCH; inc = 1'b1;
            end else begin
                p = P_BACKOFF; inc = 1'b0;
            end
            nw = w_m;
            if (lfsr_m <= p) begin
                if (inc) nw = (w_m == 3'd7) ? w_m : w_m + 3'd1;
                else     nw = (w_m == 3'd0) ? w_m : w_m - 3'd1;
            end
            if (use_tbl) nw = tw;
            exp_q.push_back(nw);
            w_m = nw;
            if ((cs & (cs - 4'd1)) != 4'd0) err_m = 1'b1;
        end
        chk("busy_draw", upd_busy, go);
        chk("done_draw", upd_done, 0);
        @(negedge clk);
        grst = 1'b0;
        chk("busy_apply", upd_busy, go);
        chk("done_apply", upd_done, go);
        @(negedge clk);
        chk("busy_after", upd_busy, 0);
        chk("done_after", upd_done, 0);
        chk("weight_after", weight, w_m);
        chk("case_err", case_err, err_m);
    endtask

    typedef struct {
        logic [3:0] cs;
        bit         ld;
        logic [2:0] wi;
        logic [2:0] ew;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int dec_cnt;
        tbl[0]  = '{4'b0001, 1'b0, 3'd0, 3'd4};
        tbl[1]  = '{4'b0001, 1'b0, 3'd0, 3'd5};
        tbl[2]  = '{4'b0001, 1'b0, 3'd0, 3'd6};
        tbl[3]  = '{4'b0001, 1'b0, 3'd0, 3'd7};
        tbl[4]  = '{4'b0001, 1'b0, 3'd0, 3'd7};
        tbl[5]  = '{4'b0001, 1'b1, 3'd1, 3'd1};
        tbl[6]  = '{4'b1000, 1'b0, 3'd0, 3'd0};
        tbl[7]  = '{4'b1000, 1'b0, 3'd0, 3'd0};
        tbl[8]  = '{4'b1000, 1'b0, 3'd0, 3'd0};
        tbl[9]  = '{4'b0000, 1'b0, 3'd0, 3'd0};
        tbl[10] = '{4'b0000, 1'b1, 3'd4, 3'd4};

        rst        = 1'b1;
        grst       = 1'b0;
        w_load     = 1'b0;
        w_in       = 3'd0;
        stdp_cases = 4'd0;
        w_m        = INIT_W;
        err_m      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_weight", weight, INIT_W);
        chk("rst_busy", upd_busy, 0);
        chk("rst_done", upd_done, 0);
        chk("rst_case_err", case_err, 0);
        rst = 1'b0;
        #1;
        chk("rst_lfsr", u_dut.lfsr, SEED);

        for (int i = 0; i < 11; i++) begin
            d0 = done_cnt;
            gamma(tbl[i].cs, tbl[i].ld, tbl[i].wi, 1'b0, 1'b1, tbl[i].ew);
            chk("tbl_weight", weight, tbl[i].ew);
            chk("tbl_dones", done_cnt - d0,
                (!tbl[i].ld && tbl[i].cs != 4'd0) ? 1 : 0);
        end

        d0 = done_cnt;
        for (int i = 0; i < 100; i++) begin
            gamma(4'b0100, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        end
        chk("search_weight", weight, 4);
        chk("search_dones", done_cnt - d0, 100);

        d0 = done_cnt;
        gamma(4'b0011, 1'b0, 3'd0, 1'b1, 1'b1, 3'd5);
        @(negedge clk);
        chk("multi_dones", done_cnt - d0, 1);
        chk("multi_err", case_err, 1);

        dec_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            load_w(3'd7);
            gamma(4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
            if (weight == 3'd6) dec_cnt++;
        end
        chk("minus_rate_ok", (dec_cnt >= 440) && (dec_cnt <= 560), 1);
        chk("err_sticky", case_err, 1);

        load_w(3'd6);
        @(negedge clk);
        stdp_cases = 4'b0001;
        @(negedge clk);
        grst = 1'b1;
        @(negedge clk);
        grst = 1'b0;
        chk("abort_busy_draw", upd_busy, 1);
        @(posedge clk);
        #1;
        chk("abort_in_apply", upd_done, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_weight", weight, INIT_W);
        chk("abort_busy", upd_busy, 0);
        chk("abort_done", upd_done, 0);
        exp_q.delete();
        pend  = 1'b0;
        w_m   = INIT_W;
        err_m = 1'b0;
        d0    = done_cnt;
        @(negedge clk);
        chk("abort_hold_weight", weight, INIT_W);
        rst = 1'b0;
        stdp_cases = 4'd0;
        #1;
        chk("abort_err_clr", case_err, 0);
        chk("abort_lfsr", u_dut.lfsr, SEED);
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);

        gamma(4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3);
        chk("nocase_dones", done_cnt - d0, 0);
        gamma(4'b1000, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stdp_weight_update.md
Name: stdp_weight_update

Overview:
- Per-synapse stochastic STDP weight updater.
- Sits directly downstream of the STDP case generator and consumes its 4-bit one-hot case vector (capture, minus, search, backoff).
- On each gamma pulse it samples the case accumulated over the previous gamma cycle. It then draws a pseudo-random number from an internal LFSR and applies a saturating +1/-1 to the stored synaptic weight with a per-case probability.
- The weight output feeds the synapse/neuron body for the next gamma cycle.

Parameters:
- WBITS, 3, weight width; weight range 0..2^WBITS-1.
- INIT_W, 0, weight value loaded on reset.
- P_CAPTURE, 16'h8000, 16-bit increment threshold for capture.
- P_MINUS, 16'h8000, 16-bit decrement threshold for minus.
- P_SEARCH, 16'h0400, 16-bit increment threshold for search.
- P_BACKOFF, 16'h8000, 16-bit decrement threshold for backoff.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk  in  1  unit clock for temporal encoding.
- rst  in  1  asynchronous active-high reset.
- grst  in  1  one-cycle gamma pulse.
- stdp_cases  in  4  [0]=capture, [1]=minus, [2]=search, [3]=backoff; held until gamma.
- w_load  in  1  synchronous weight load strobe.
- w_in  in  WBITS  weight value for w_load.
- weight  out  WBITS  current synaptic weight.
- upd_busy  out  1  high while the update FSM is not IDLE.
- upd_done  out  1  one-cycle pulse when the weight write completes (changed or not).
- case_err  out  1  sticky; set if more than one case bit is sampled simultaneously.

Behaviour:
- Reset (async, rst=1): weight=INIT_W, lfsr=LFSR_SEED, case_q=0, FSM=IDLE, upd_busy=0, upd_done=0, case_err=0.
- case_q register: case_q <= stdp_cases every clk. At the grst cycle, the upstream vector may already be cleared, so the sample used is case_q, i.e. the value from the cycle before grst.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every clk except in reset. It never reaches 0.
- Hit rule: hit = (lfsr <= P_sel).
  - P=16'h0000 never fires (lfsr is never 0).
  - P=16'hFFFF always fires.
- FSM states IDLE, DRAW, APPLY:
  - IDLE: on grst=1 with case_q!=0, latch sel=case_q and go to DRAW. On grst with case_q==0, stay IDLE with no upd_done.
  - DRAW (1 cycle): priority-select the case as capture > minus > search > backoff; set case_err if popcount(sel)>1. Register hit (using lfsr at this cycle) and direction (inc for capture/search, dec for minus/backoff). Go to APPLY.
  - APPLY (1 cycle): if hit, weight <= inc ? sat_max(weight+1) : sat_min(weight-1). Pulse upd_done; go to IDLE.
- Latency: grst at cycle N gives the weight change visible at cycle N+3 (registered in APPLY at edge N+2→N+3). upd_done is high during cycle N+2 (APPLY). upd_busy is high during N+1..N+2.
- Saturation:
  - Increment at 2^WBITS-1 holds.
  - Decrement at 0 holds.
  - Both still pulse upd_done.
- grst while upd_busy: ignored; no queuing.
- w_load:
  - Honoured only in IDLE: weight <= w_in next edge.
  - In DRAW/APPLY it is ignored.
  - Simultaneous w_load and grst in IDLE: load wins, update is skipped.
- Reset mid-operation: FSM aborts to IDLE immediately and weight returns to INIT_W. No upd_done is produced.
- case_err is cleared only by rst.

Test Plan:
- Reset with INIT_W=3: weight=3, upd_busy=0, upd_done=0, case_err=0; lfsr=16'hACE1 after rst release.
- P_CAPTURE=16'hFFFF, stdp_cases=4'b0001 held then grst: upd_done at grst+2, weight 3→4 at grst+3. Repeat 5 times → saturates at 7, upd_done still pulses.
- P_BACKOFF=16'hFFFF, stdp_cases=4'b1000, weight=1: two gammas → 0, 0; a third gamma keeps 0.
- P_SEARCH=16'h0000, stdp_cases=4'b0100, 100 gammas: weight unchanged, 100 upd_done pulses. Then P_MINUS=16'h8000 over 1000 gammas with w_load=7 each time: decrement count within 500±60.
- stdp_cases=4'b0011 at grst: capture applied (increment when hit), case_err=1 and stays set until rst. grst at grst+1 is ignored (exactly one upd_done). w_load in IDLE concurrent with grst loads w_in, no upd_done.
- rst asserted during APPLY: weight=INIT_W asynchronously, upd_busy=0, no upd_done. stdp_cases=0 at grst: no upd_busy, no upd_done.
